// File: rtl/bootrom_arbiter.sv
`timescale 1ns/1ps
// Two-port (CPU / SPI loader) arbiter and access sequencer for the 16-word boot ROM/scratch block.
// Latency: legal access acks 2 cycles after the accepting IDLE edge, illegal access 1 cycle after.
// Backpressure: requests are held until ack; BOOTARB_ROUND_ROBIN_EN selects round-robin over fixed CPU priority.
module bootrom_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_err,
  output logic              rom_cs,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_din,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCESS   = 2'd1;
  localparam logic [1:0] ST_RESP     = 2'd2;
  localparam logic [1:0] ST_ERR_RESP = 2'd3;

  logic [1:0]        state;
  logic              lat_we;
  logic              lat_spi;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] spi_rdata_q;

  logic              any_req;
  logic              grant_spi;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  function automatic logic wr_legal(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(7)) || (a == ADDR_W'(14)) || (a == ADDR_W'(15));
  endfunction

  // Readable: ROM words 0..6, scratch 7/E/F; 8..D and anything above 15 are unmapped.
  function automatic logic rd_legal(input logic [ADDR_W-1:0] a);
    return (a <= ADDR_W'(7)) || (a == ADDR_W'(14)) || (a == ADDR_W'(15));
  endfunction

  assign any_req = cpu_req | spi_req;

`ifdef BOOTARB_ROUND_ROBIN_EN
  logic last_spi;

  // Tie goes to whoever was not served last; starts as "SPI last" so CPU wins the first tie.
  assign grant_spi = spi_req & (~cpu_req | ~last_spi);

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_spi <= 1'b1;
    else if (state == ST_IDLE && any_req)
      last_spi <= grant_spi;
  end
`else
  assign grant_spi = spi_req & ~cpu_req;
`endif

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_spi) begin
      sel_we    = spi_we;
      sel_addr  = spi_addr;
      sel_wdata = spi_wdata;
    end
    sel_err = sel_we ? ~wr_legal(sel_addr) : ~rd_legal(sel_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lat_we      <= 1'b0;
      lat_spi     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      cpu_rdata_q <= '0;
      spi_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            lat_we    <= sel_we;
            lat_spi   <= grant_spi;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            if (sel_err) begin
              state <= ST_ERR_RESP;
              // Failed reads return zero in the ack cycle; failed writes keep the old read data.
              if (!sel_we) begin
                if (grant_spi)
                  spi_rdata_q <= '0;
                else
                  cpu_rdata_q <= '0;
              end
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!lat_we) begin
            if (lat_spi)
              spi_rdata_q <= rom_dout;
            else
              cpu_rdata_q <= rom_dout;
          end
          state <= ST_RESP;
        end
        ST_RESP:     state <= ST_IDLE;
        ST_ERR_RESP: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are gated by rst_n so a write caught by reset never reaches the block.
  assign rom_cs    = (state == ST_ACCESS) && rst_n;
  assign rom_we    = rom_cs && lat_we;
  assign rom_addr  = lat_addr;
  assign rom_din   = lat_wdata;

  assign cpu_ack   = ((state == ST_RESP) || (state == ST_ERR_RESP)) && !lat_spi;
  assign spi_ack   = ((state == ST_RESP) || (state == ST_ERR_RESP)) && lat_spi;
  assign cpu_err   = (state == ST_ERR_RESP) && !lat_spi;
  assign spi_err   = (state == ST_ERR_RESP) && lat_spi;
  assign cpu_rdata = cpu_rdata_q;
  assign spi_rdata = spi_rdata_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: doc/bootrom_arbiter.md
Name: bootrom_arbiter

Overview:
- Two-port arbiter and access sequencer for the 16-word boot ROM/scratch register block.
- Shares the block between the CPU fetch/load port and the SPI loader port.
- Generates the block's cs/we/addr/din strobes, captures its latch-based read data into a register, and returns a one-cycle ack per transaction.
- Enforces the write map: writable words are 0x7, 0xE and 0xF only; ROM words are 0x0–0x6; 0x8–0xD are unmapped.

Parameters:
ADDR_W, 4, word address width of the boot block
DATA_W, 16, data width

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  synchronous active-low reset
cpu_req  input  1  CPU request; held with cpu_we/cpu_addr/cpu_wdata until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data
cpu_ack  output  1  one-cycle completion pulse
cpu_rdata  output  DATA_W  read data, valid while cpu_ack=1, held until next CPU read completes
cpu_err  output  1  valid with cpu_ack: illegal write or unmapped read
spi_req, spi_we, spi_addr, spi_wdata  input  1/1/ADDR_W/DATA_W  SPI loader request (same rules as CPU)
spi_ack, spi_rdata, spi_err  output  1/DATA_W/1  SPI responses (same rules as CPU)
rom_cs  output  1  boot block chip select
rom_we  output  1  boot block write enable
rom_addr  output  ADDR_W  boot block address
rom_din  output  DATA_W  boot block write data
rom_dout  input  DATA_W  boot block read data (transparent while cs & ~we)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - rom_cs, rom_we, acks, errs and busy go to 0.
  - rom_addr, rom_din, both rdata registers and the captured-request registers go to 0.
  - Reset during ACCESS drops rom_cs on that same edge, so no write is issued afterwards.
- States: IDLE, ACCESS, RESP, plus ERR_RESP.
- IDLE:
  - Samples the requests and picks a winner.
  - Latches the winner's we, addr and wdata, and a winner ID.
  - Illegal write (addr not 7/E/F) or unmapped read (addr 8–D) goes to ERR_RESP; otherwise goes to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drives rom_cs=1, rom_we=latched we, rom_addr, rom_din.
  - A write completes on this cycle's rising clk inside the boot block.
  - On the exit edge, a read loads rom_dout into the winner's rdata register.
  - Next state is RESP.
- RESP (1 cycle):
  - rom_cs=0, rom_we=0.
  - Winner's ack=1, err=0.
  - Next state is IDLE.
- ERR_RESP (1 cycle):
  - rom_cs stays 0; no boot block access of any kind.
  - Winner's ack=1, err=1; winner's rdata is set to 0 for reads and left unchanged for writes.
  - Next state is IDLE.
- Latency:
  - Legal access: ack is high 2 cycles after the IDLE edge that accepted the request.
  - Error access: ack is high 1 cycle after that edge.
- Throughput: a minimum of 3 cycles per legal transaction, because IDLE always takes one cycle.
- Requester rules:
  - A request still high in the cycle after its ack is treated as a new request.
  - Requesters deassert req in their ack cycle for single transfers.
  - Request inputs are captured in IDLE, so changes after capture do not affect the transaction in flight.
- The loser of an arbitration keeps req high and is served in the next arbitration.
- rom_we is never asserted without rom_cs, and only for addresses 7, E and F.
- rom_cs is asserted only in ACCESS.
- Arbitration (default, fixed priority): CPU wins whenever cpu_req=1.
- Address comparison uses the full ADDR_W bits; there is no wrap-around or aliasing.

Optional Feature:
- Macro: BOOTARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-served pointer updates on every accepted request.
  - On simultaneous requests, the requester that was not served last wins.
  - The pointer resets to "SPI last", so the CPU wins the first tie.
  - A single requester is always served immediately.
- Not defined: fixed CPU priority as above; no pointer flop exists.

Test Plan:
- Reset, then CPU read of addr 0x0 and then 0x4 -> rom_cs high exactly 1 cycle each; cpu_rdata=0xF200, then 0xB007; cpu_err=0; ack 2 cycles after acceptance.
- SPI write of 0x1234 to addr 0x7, then SPI read of 0x7 -> rom_we/rom_cs high together for 1 cycle; spi_rdata=0x1234; repeat for 0xE (0xBEEF) and 0xF (0xA5A5).
- CPU write to 0x2 and CPU read of 0xA -> rom_cs stays 0 throughout; cpu_ack with cpu_err=1; rdata=0 after the read; a following read of 0x2 returns 0xF800.
- cpu_req and spi_req both held high for 4 transactions:
  - Macro off: CPU is served until it drops req, and only then SPI.
  - Macro on: grants alternate CPU, SPI, CPU, SPI.
- rst_n pulled low during ACCESS of a write of 0x5555 to 0x7 -> rom_cs/rom_we go to 0 on that edge, busy=0, no ack; a post-reset read of 0x7 does not return 0x5555.
- Back-to-back: cpu_req held high for 3 reads -> acks spaced exactly 3 cycles apart; busy low for exactly one cycle between transactions.
